// File: rtl/led_pkg.sv
// Shared constants and types for the LED line index encoder and its decoder.
package led_pkg;

  localparam int N_LINES = 32;
  localparam int IDX_W   = $clog2(N_LINES);
  localparam int CNT_W   = IDX_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } led_state_t;

  typedef logic [IDX_W-1:0] led_idx_t;

endpackage

// File: rtl/led_prio_enc.sv
// Combinational lowest-set-bit encoder: N_LINES request lines to one index.
module led_prio_enc
  import led_pkg::*;
(
  input  logic [N_LINES-1:0] req,
  output led_idx_t           idx,
  output logic               any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = led_idx_t'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/led_index_encoder.sv
// Latches a 32-line LED request mask and streams the set line indices,
// lowest first, one per accepted valid/ready handshake.
module led_index_encoder
  import led_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LINES-1:0] req,
  input  logic               load,
  input  logic               abort,
  output logic [IDX_W-1:0]   idx,
  output logic               idx_valid,
  input  logic               idx_ready,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   count
);

  led_state_t         state_q, state_d;
  logic [N_LINES-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;

  led_idx_t           enc_idx;
  logic               enc_any;
  logic               hs;
  logic [N_LINES-1:0] onehot;
  logic [N_LINES-1:0] nxt;

  led_prio_enc u_prio_enc (
    .req (pending_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Output view of the registered frame; idx is 0 whenever nothing is pending.
  always_comb begin
    idx       = enc_idx;
    idx_valid = (state_q == ST_SCAN) && enc_any;
    busy      = (state_q != ST_IDLE);
    done      = done_q;
    count     = count_q;
  end

  // Next-state logic: abort overrides everything, load only acts in IDLE.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    done_d    = 1'b0;
    hs        = idx_valid && idx_ready;
    onehot    = {{(N_LINES-1){1'b0}}, 1'b1} << enc_idx;
    nxt       = hs ? (pending_q & ~onehot) : pending_q;

    if (abort) begin
      state_d   = ST_IDLE;
      pending_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            pending_d = req;
            count_d   = '0;
            state_d   = ST_SCAN;
          end
        end
        ST_SCAN: begin
          pending_d = nxt;
          count_d   = count_q + {{(CNT_W-1){1'b0}}, hs};
          if (nxt == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          pending_d = '0;
        end
      endcase
    end
  end

  // State, frame and count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

endmodule
